multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore/Mealy state machine that steps each instruction through fetch, decode, execute, memory and writeback. Instruction and data share one memory port, and each memory phase waits on a ready handshake. It sits between the instruction register (opcode/funct source), the shared memory, the ALU and the register file.

---
 rtl/multicycle_control.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/memory/writeback with a shared memory port.
// Defining MC_EXC_EN adds the exc port and a TRAP state for illegal instructions.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       jal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       zero_ext,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic [3:0] state
`ifdef MC_EXC_EN
  , output logic     exc
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2,  S_MEM_RD = 4'd3,
    S_MEM_WB  = 4'd4,  S_MEM_WR = 4'd5,  S_R_EXEC  = 4'd6,  S_R_WB   = 4'd7,
    S_BRANCH  = 4'd8,  S_JUMP   = 4'd9,  S_I_EXEC  = 4'd10, S_I_WB   = 4'd11,
    S_JR      = 4'd12, S_JAL    = 4'd13, S_TRAP    = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1110;

  state_t state_q, state_d;
  // Low from reset until the first clock edge after release; keeps every output quiet meanwhile.
  logic   active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  logic is_rtype, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_addi, is_ori;
  assign is_rtype = (opcode == 6'b000000);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bne   = (opcode == 6'b000101);
  assign is_j     = (opcode == 6'b000010);
  assign is_jal   = (opcode == 6'b000011);
  assign is_addi  = (opcode == 6'b001000);
  assign is_ori   = (opcode == 6'b001101);

  logic [3:0] r_alu;
  logic       r_known;

  always_comb begin
    r_alu   = ALU_ADD;
    r_known = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      6'b000000: r_alu = ALU_SLL;
      default:   r_known = 1'b0;
    endcase
  end

  logic pc_write, branch_taken;

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    jal          = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_control  = ALU_AND;
    zero_ext     = 1'b0;
    pc_src       = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        if (is_jr)                       state_d = S_JR;
        else if (is_rtype && r_known)    state_d = S_R_EXEC;
        else if (is_lw || is_sw)         state_d = S_MEM_ADR;
        else if (is_beq || is_bne)       state_d = S_BRANCH;
        else if (is_j)                   state_d = S_JUMP;
        else if (is_jal)                 state_d = S_JAL;
        else if (is_addi || is_ori)      state_d = S_I_EXEC;
        else
`ifdef MC_EXC_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
      end
      S_MEM_ADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = is_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        alu_control = r_alu;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_control  = ALU_SUB;
        pc_src       = 2'b01;
        branch_taken = (is_beq && zero) || (is_bne && !zero);
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_src    = 2'b10;
        reg_write = 1'b1;
        jal       = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
        state_d  = S_FETCH;
      end
      S_I_EXEC, S_I_WB: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = is_ori ? ALU_OR : ALU_ADD;
        zero_ext    = is_ori;
        reg_write   = (state_q == S_I_WB);
        state_d     = (state_q == S_I_WB) ? S_FETCH : S_I_WB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    if (!active_q) begin
      state_d      = state_q;
      pc_write     = 1'b0;
      branch_taken = 1'b0;
      iord         = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      jal          = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_control  = ALU_AND;
      zero_ext     = 1'b0;
      pc_src       = 2'b00;
    end

    pc_en      = pc_write || branch_taken;
    instr_done = (state_q != S_FETCH) && (state_d == S_FETCH);
  end

  assign state = state_q;

`ifdef MC_EXC_EN
  assign exc = active_q && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a scoreboard queue,
// plus hand-written reset and illegal-instruction sequences.
module tb_multicycle_control;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, jal, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control, state;
  logic       zero_ext, instr_done;
`ifdef MC_EXC_EN
  logic       exc;
`endif

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control), .zero_ext(zero_ext),
    .pc_src(pc_src), .instr_done(instr_done), .state(state)
`ifdef MC_EXC_EN
    , .exc(exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       zero_ext;
    logic [1:0] pc_src;
    logic       instr_done;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, rdy;
    outs_t      exp;
  } vec_t;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001, SLT = 4'b0111, SLL = 4'b1110;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BAD = 6'b111111;

  vec_t  vecs[$];
  outs_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic outs_t mk(input logic [3:0] st, input logic pe, io, mr, mw, irw, rw, rd, m2r, jl, asa,
                               input logic [1:0] asb, input logic [3:0] ac, input logic ze,
                               input logic [1:0] ps, input logic dn);
    outs_t o;
    o.pc_en = pe; o.iord = io; o.mem_read = mr; o.mem_write = mw; o.ir_write = irw;
    o.reg_write = rw; o.reg_dst = rd; o.mem_to_reg = m2r; o.jal = jl; o.alu_src_a = asa;
    o.alu_src_b = asb; o.alu_control = ac; o.zero_ext = ze; o.pc_src = ps; o.instr_done = dn; o.state = st;
    return o;
  endfunction

  function automatic outs_t get_act();
    return mk(state, pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, jal,
              alu_src_a, alu_src_b, alu_control, zero_ext, pc_src, instr_done);
  endfunction

  task automatic cmp(input string nm, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got outputs %h, expected %h (state got %0d exp %0d)", nm, act, exp, act.state, exp.state);
    else
      n_pass++;
  endtask

  task automatic add(input logic [5:0] op, fn, input logic z, r, input outs_t e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  // FETCH cycle: IR load and PC write happen only in the ready cycle.
  task automatic fetch(input logic [5:0] op, fn, input logic z, r);
    add(op, fn, z, r, mk(4'd0, r, 0, 1, 0, r, 0, 0, 0, 0, 0, 2'b01, ADD, 0, 2'b00, 0));
  endtask

  task automatic dec(input logic [5:0] op, fn, input logic z, dn);
    add(op, fn, z, 1'b1, mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 2'b00, dn));
  endtask

  task automatic branch(input logic [5:0] op, input logic z, taken);
    fetch(op, 6'd0, z, 1); dec(op, 6'd0, z, 0);
    add(op, 6'd0, z, 1, mk(4'd8, taken, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, SUB, 0, 2'b01, 1));
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [3:0] ac);
    fetch(OP_R, fn, 0, 1); dec(OP_R, fn, 0, 0);
    add(OP_R, fn, 0, 1, mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ac, 0, 2'b00, 0));
    add(OP_R, fn, 0, 1, mk(4'd7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, ac, 0, 2'b00, 1));
  endtask

  task automatic itype(input logic [5:0] op, input logic [3:0] ac, input logic ze);
    fetch(op, 6'd0, 0, 1); dec(op, 6'd0, 0, 0);
    add(op, 6'd0, 0, 1, mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ac, ze, 2'b00, 0));
    add(op, 6'd0, 0, 1, mk(4'd11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b10, ac, ze, 2'b00, 1));
  endtask

  task automatic build_table();
    // lw, memory always ready: states 0,1,2,3,4
    fetch(OP_LW, 0, 0, 1); dec(OP_LW, 0, 0, 0);
    add(OP_LW, 0, 0, 1, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 2'b00, 0));
    add(OP_LW, 0, 0, 1, mk(4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0));
    add(OP_LW, 0, 0, 1, mk(4'd4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, AND, 0, 2'b00, 1));
    // sw with three wait cycles; mem_ready is high (ignored) in DECODE and MEM_ADR
    fetch(OP_SW, 0, 0, 1); dec(OP_SW, 0, 0, 0);
    add(OP_SW, 0, 0, 1, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 2'b00, 0));
    for (int i = 0; i < 3; i++)
      add(OP_SW, 0, 0, 0, mk(4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0));
    add(OP_SW, 0, 0, 1, mk(4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 1));
    branch(OP_BEQ, 1, 1);
    branch(OP_BEQ, 0, 0);
    branch(OP_BNE, 0, 1);
    branch(OP_BNE, 1, 0);
    rtype(6'b101010, SLT);
    rtype(6'b000000, SLL);
    rtype(6'b100010, SUB);
    // jr
    fetch(OP_R, 6'b001000, 0, 1); dec(OP_R, 6'b001000, 0, 0);
    add(OP_R, 6'b001000, 0, 1, mk(4'd12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b11, 1));
    itype(OP_ORI, OR, 1);
    itype(OP_ADDI, ADD, 0);
    // jal
    fetch(OP_JAL, 0, 0, 1); dec(OP_JAL, 0, 0, 0);
    add(OP_JAL, 0, 0, 1, mk(4'd13, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, AND, 0, 2'b10, 1));
    // j preceded by two fetch wait cycles
    fetch(OP_J, 0, 0, 0); fetch(OP_J, 0, 0, 0); fetch(OP_J, 0, 0, 1); dec(OP_J, 0, 0, 0);
    add(OP_J, 0, 0, 1, mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b10, 1));
`ifndef MC_EXC_EN
    // illegal opcode and illegal funct retire as 2-cycle NOPs
    fetch(OP_BAD, 0, 0, 1); dec(OP_BAD, 0, 0, 1);
    fetch(OP_R, 6'b111111, 0, 1); dec(OP_R, 6'b111111, 0, 1);
`endif
  endtask

  task automatic drive(input logic [5:0] op, fn, input logic z, r);
    opcode = op; funct = fn; zero = z; mem_ready = r;
  endtask

  outs_t zero_outs;
  initial zero_outs = '0;

  initial begin
    rst_n = 1'b0;
    drive(OP_LW, 6'd0, 1'b1, 1'b1);
    build_table();
    repeat (2) @(posedge clk);
    #1 cmp("reset_outputs_zero", get_act(), zero_outs);
    @(negedge clk); #2 rst_n = 1'b1;
    #1 cmp("released_before_edge", get_act(), zero_outs);

    // table-driven vectors through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: got queue size 0, expected at least 1");
      end else begin
        cmp($sformatf("vec%0d", i), get_act(), exp_q.pop_front());
      end
    end

    // reset in the middle of an R-type abandons it without writeback or instr_done
    @(posedge clk); #1 drive(OP_R, 6'b100000, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("mid_r_exec", get_act(), mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ADD, 0, 2'b00, 0));
    rst_n = 1'b0;
    #1 cmp("async_reset_clears", get_act(), zero_outs);
    @(posedge clk); #1 cmp("reset_held", get_act(), zero_outs);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 cmp("fetch_after_reset", get_act(), mk(4'd0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, ADD, 0, 2'b00, 0));
    @(posedge clk); #1 cmp("decode_after_reset", get_act(), mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 2'b00, 0));

`ifdef MC_EXC_EN
    rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 drive(OP_BAD, 6'd0, 0, 1);
    @(posedge clk); #1 cmp("bad_decode", get_act(), mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 2'b00, 0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp($sformatf("trap%0d", i), get_act(), mk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0));
      n_checks++;
      if (exc !== 1'b1) $display("FAIL trap_exc%0d: got exc %b, expected 1", i, exc);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (exc !== 1'b0 || state !== 4'd0) $display("FAIL trap_reset: got exc %b state %0d, expected 0 0", exc, state);
    else n_pass++;
    @(negedge clk); #2 rst_n = 1'b1;
`endif

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
